// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store unit sitting behind the ALU.
//
// Takes the ALU result as the effective address, runs one request/grant/
// response transaction at a time against data memory, steers byte lanes for
// stores and extracts + sign/zero-extends load data. The core is stalled
// while an access is in flight.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses skip memory, complete in one cycle
//               with lsu_misalign_o=1 (and, for loads, lsu_rdata_o=0).
//   undefined : lsu_misalign_o tied to 0, misaligned offsets are aligned down.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   lsu_addr_i             effective byte address
//   lsu_wdata_i            store data (rs2)
//   lsu_rd_i / lsu_wr_i    load / store request (store wins if both)
//   lsu_funct3_i           000 B, 001 H, 010 W, 100 BU, 101 HU (others = W)
//   lsu_stall_o            hold PC/instruction
//   lsu_done_o             one-cycle completion pulse
//   lsu_rdata_o            registered, extended load result
//   lsu_misalign_o         misaligned flag, valid with lsu_done_o
//   mem_req_o/we_o         request valid / write
//   mem_addr_o             word-aligned address (DMEM_AW bits, 3..32)
//   mem_wdata_o/be_o       lane-replicated write data / byte enables
//   mem_gnt_i              request accepted
//   mem_rvalid_i/rdata_i   read data valid / read word
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        lsu_addr_i,
  input  logic [31:0]        lsu_wdata_i,
  input  logic               lsu_rd_i,
  input  logic               lsu_wr_i,
  input  logic [2:0]         lsu_funct3_i,
  output logic               lsu_stall_o,
  output logic               lsu_done_o,
  output logic [31:0]        lsu_rdata_o,
  output logic               lsu_misalign_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [DMEM_AW-1:0] mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  output logic [3:0]         mem_be_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Undefined funct3 encodings fall through to word size.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  state_e             state_q;
  logic [1:0]         addr_lo_q;
  logic [2:0]         funct3_q;
  logic               we_q;
  logic               req_q;
  logic [DMEM_AW-1:0] mem_addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               done_q;

  size_e              size_d;
  logic [3:0]         be_d;
  logic [31:0]        wdata_d;
  logic [DMEM_AW-1:0] word_addr_d;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ext_d;

  // Store lane steering, computed from the live request so it can be latched
  // in the IDLE cycle. Halfword lanes use addr[1] only, so a misaligned
  // halfword is naturally aligned down.
  always_comb begin
    size_d  = size_of(lsu_funct3_i);
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (size_d)
      SZ_B: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      SZ_H: begin
        be_d    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
      end
    endcase
  end

  assign word_addr_d = {lsu_addr_i[DMEM_AW-1:2], 2'b00};

  // Load extraction works on the latched offset/funct3 and the live read word.
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ext_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ext_d = {24'h0, ld_byte};
      3'b001:  ext_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  ext_d = {16'h0, ld_half};
      default: ext_d = mem_rdata_i;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_d;
  logic misalign_q;

  always_comb begin
    misalign_d = 1'b0;
    case (size_d)
      SZ_H:    misalign_d = lsu_addr_i[0];
      SZ_W:    misalign_d = (lsu_addr_i[1:0] != 2'b00);
      default: misalign_d = 1'b0;
    endcase
  end
`endif

  // Single FSM block; every memory-side and completion output is a register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_lo_q  <= 2'b00;
      funct3_q   <= 3'b000;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      mem_addr_q <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (lsu_rd_i || lsu_wr_i) begin
            addr_lo_q  <= lsu_addr_i[1:0];
            funct3_q   <= lsu_funct3_i;
            we_q       <= lsu_wr_i;
            mem_addr_q <= word_addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_d) begin
              // Trap path: no memory traffic, complete next cycle. Stores
              // leave the load result alone.
              state_q    <= DONE;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
              if (!lsu_wr_i) begin
                rdata_q <= 32'h0;
              end
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
`else
            state_q <= REQ;
            req_q   <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            req_q <= 1'b0;
            if (we_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= ext_d;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The request cycle itself stalls, so this is decoded combinationally;
  // gating with rst_ni makes stall fall together with the async reset.
  assign lsu_stall_o = rst_ni & (((state_q == IDLE) & (lsu_rd_i | lsu_wr_i)) |
                                 (state_q == REQ) | (state_q == WAIT));

  assign lsu_done_o  = done_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu_misalign_o = misalign_q;
`else
  assign lsu_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Directed vector table, hand-written reset / misalign sequences, then
// random traffic against a word-array memory and an arithmetic lane model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_rd, lsu_wr;
  logic [2:0]  lsu_funct3;
  logic        lsu_stall, lsu_done, lsu_misalign;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  logic [31:0] last_rdata;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  lsu_ctrl #(.DMEM_AW(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_rd_i(lsu_rd), .lsu_wr_i(lsu_wr), .lsu_funct3_i(lsu_funct3),
    .lsu_stall_o(lsu_stall), .lsu_done_o(lsu_done),
    .lsu_rdata_o(lsu_rdata), .lsu_misalign_o(lsu_misalign),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rword;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gd, input int rvd, input logic [31:0] rword,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.gnt_dly = gd; v.rv_dly = rvd; v.rword = rword;
    v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  // Reference: access width in bytes, offset aligned down to that width,
  // lanes and extension computed with plain shifts/masks/multiplies.
  function automatic void model(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rword,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] rd);
    int     nb, off;
    longint mask, v, rep;
    nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = (int'(addr[1:0]) / nb) * nb;
    mask = (64'sd1 <<< (8 * nb)) - 1;
    be   = 4'(((1 << nb) - 1) << off);
    rep  = (nb == 1) ? 64'sh01010101 : (nb == 2) ? 64'sh00010001 : 64'sd1;
    wd   = 32'((longint'(wdata) & mask) * rep);
    v    = (longint'(rword) >>> (8 * off)) & mask;
    if (!f3[2] && nb < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
    rd   = 32'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Runs one complete access starting at a falling edge and checks every cycle.
  task automatic run_vec(input vec_t v);
    logic st;
    st = v.wr;
    lsu_rd = v.rd; lsu_wr = v.wr; lsu_funct3 = v.f3;
    lsu_addr = v.addr; lsu_wdata = v.wdata;
    #1;
    check("stall_c0", lsu_stall, 1);
    check("req_c0", mem_req, 0);
    @(negedge clk);
    lsu_rd = 0; lsu_wr = 0; lsu_addr = $urandom; lsu_wdata = $urandom;
    for (int i = 0; i <= v.gnt_dly; i++) begin
      mem_gnt    = (i == v.gnt_dly);
      mem_rvalid = (i != v.gnt_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata  = $urandom;
      #1;
      check("req", mem_req, 1);
      check("we", mem_we, st);
      check("addr", mem_addr, v.exp_addr);
      check("be", mem_be, v.exp_be);
      if (st) check("wdata", mem_wdata, v.exp_wdata);
      check("stall_req", lsu_stall, 1);
      check("done_req", lsu_done, 0);
      @(negedge clk);
    end
    mem_gnt = 0; mem_rvalid = 0;
    if (!st) begin
      for (int j = 1; j <= v.rv_dly; j++) begin
        mem_rvalid = (j == v.rv_dly);
        mem_rdata  = (j == v.rv_dly) ? v.rword : $urandom;
        #1;
        check("req_wait", mem_req, 0);
        check("stall_wait", lsu_stall, 1);
        check("done_wait", lsu_done, 0);
        @(negedge clk);
      end
      last_rdata = v.exp_rdata;
    end
    mem_rvalid = 0; mem_rdata = $urandom;
    lsu_rd = 1; lsu_funct3 = 3'($urandom); // ignored in DONE
    #1;
    check("done", lsu_done, 1);
    check("stall_done", lsu_stall, 0);
    check("misalign", lsu_misalign, 0);
    check("rdata", lsu_rdata, last_rdata);
    @(negedge clk);
    lsu_rd = 0;
    #1;
    check("done_pulse", lsu_done, 0);
    check("stall_idle", lsu_stall, 0);
    check("rdata_hold", lsu_rdata, last_rdata);
    @(negedge clk);
    #1;
    check("req_idle", mem_req, 0);
    $display("txn %0d: %s f3=%0d addr=0x%08h gnt_dly=%0d rv_dly=%0d rdata=0x%08h",
             txn, st ? "store" : "load ", v.f3, v.addr, v.gnt_dly, v.rv_dly, lsu_rdata);
    txn++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; lsu_rd = 0; lsu_wr = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; last_rdata = 0;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", lsu_done, 0);
    check("rst_misalign", lsu_misalign, 0);
    check("rst_rdata", lsu_rdata, 0);
    check("rst_stall", lsu_stall, 0);
    rst_n = 1;
    @(negedge clk);

    // Directed table
    vecs.push_back(mk(0,1,3'b000,32'h103,32'hA5,0,1,0,32'h100,4'b1000,32'hA5A5A5A5,0));
    vecs.push_back(mk(1,0,3'b000,32'h102,0,0,1,32'h00F00000,32'h100,4'b0100,0,32'hFFFFFFF0));
    vecs.push_back(mk(1,0,3'b100,32'h102,0,0,1,32'h00F00000,32'h100,4'b0100,0,32'h000000F0));
    vecs.push_back(mk(1,0,3'b010,32'h200,0,3,2,32'hDEADBEEF,32'h200,4'b1111,0,32'hDEADBEEF));
    vecs.push_back(mk(1,1,3'b010,32'h204,32'h12345678,1,1,0,32'h204,4'b1111,32'h12345678,0));
    vecs.push_back(mk(0,1,3'b001,32'h102,32'h5555CAFE,0,1,0,32'h100,4'b1100,32'hCAFECAFE,0));
    vecs.push_back(mk(1,0,3'b101,32'h006,0,0,1,32'h80017FFF,32'h004,4'b1100,0,32'h00008001));
    vecs.push_back(mk(1,0,3'b001,32'h002,0,1,1,32'h80017FFF,32'h000,4'b1100,0,32'hFFFF8001));
    vecs.push_back(mk(1,0,3'b000,32'h001,0,0,2,32'h00007F00,32'h000,4'b0010,0,32'h0000007F));
    vecs.push_back(mk(1,0,3'b011,32'h010,0,2,3,32'h89ABCDEF,32'h010,4'b1111,0,32'h89ABCDEF));
    vecs.push_back(mk(0,1,3'b000,32'hFC,32'hFFFFFF3C,0,1,0,32'hFC,4'b0001,32'h3C3C3C3C,0));
    vecs.push_back(mk(1,0,3'b100,32'h003,0,0,1,32'h80000000,32'h000,4'b1000,0,32'h00000080));
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0,1,3'b010,32'h107,32'h11223344,0,1,0,32'h104,4'b1111,32'h11223344,0));
    vecs.push_back(mk(1,0,3'b001,32'h101,0,0,1,32'h12348765,32'h100,4'b0011,0,32'hFFFF8765));
`endif
    foreach (vecs[n]) run_vec(vecs[n]);

    // Reset while in REQ drops the request at once
    @(negedge clk);
    lsu_wr = 1; lsu_funct3 = 3'b010; lsu_addr = 32'h40; lsu_wdata = 32'h1;
    @(negedge clk);
    lsu_wr = 0;
    #1;
    check("req_before_rst", mem_req, 1);
    rst_n = 0;
    #1;
    check("rst_req_in_req", mem_req, 0);
    check("rst_stall_in_req", lsu_stall, 0);
    @(negedge clk);
    rst_n = 1;
    last_rdata = 0;
    @(negedge clk);
    // Re-establish a non-zero load result, then reset while in WAIT
    run_vec(mk(1,0,3'b010,32'h44,0,0,1,32'hA5A50F0F,32'h44,4'b1111,0,32'hA5A50F0F));
    @(negedge clk);
    lsu_rd = 1; lsu_funct3 = 3'b010; lsu_addr = 32'h48;
    @(negedge clk);
    lsu_rd = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    #1;
    check("stall_wait_pre_rst", lsu_stall, 1);
    check("rdata_pre_rst", lsu_rdata, last_rdata);
    rst_n = 0;
    #1;
    check("rst_req_in_wait", mem_req, 0);
    check("rst_stall_in_wait", lsu_stall, 0);
    check("rst_rdata_in_wait", lsu_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    last_rdata = 0;
    @(negedge clk);
    run_vec(mk(0,1,3'b010,32'h300,32'h0BADF00D,0,1,0,32'h300,4'b1111,32'h0BADF00D,0));

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned LH: no request, single-cycle stall, flag + zero result
    run_vec(mk(1,0,3'b010,32'h4C,0,0,1,32'h77777777,32'h4C,4'b1111,0,32'h77777777));
    lsu_rd = 1; lsu_funct3 = 3'b001; lsu_addr = 32'h101;
    #1;
    check("trap_stall_c0", lsu_stall, 1);
    @(negedge clk);
    lsu_rd = 0;
    #1;
    check("trap_req", mem_req, 0);
    check("trap_done", lsu_done, 1);
    check("trap_misalign", lsu_misalign, 1);
    check("trap_rdata", lsu_rdata, 0);
    check("trap_stall_c1", lsu_stall, 0);
    last_rdata = 0;
    @(negedge clk);
    #1;
    check("trap_done_pulse", lsu_done, 0);
    check("trap_misalign_pulse", lsu_misalign, 0);
    check("trap_req_after", mem_req, 0);
    @(negedge clk);
`endif

    // Random traffic against the memory array
    for (int r = 0; r < 150; r++) begin
      vec_t v;
      logic [3:0]  be;
      logic [31:0] wd, rdv;
      int          idx;
      v.wr = 1'($urandom_range(0, 1));
      v.rd = v.wr ? ($urandom_range(0, 7) == 0) : 1'b1;
      v.f3 = v.wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      v.addr = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
`ifdef LSU_MISALIGN_TRAP_EN
      if (v.f3[1:0] == 2'b01) v.addr[0] = 1'b0;
      else if (v.f3[1:0] != 2'b00) v.addr[1:0] = 2'b00;
`endif
      v.wdata   = $urandom;
      v.gnt_dly = $urandom_range(0, 3);
      v.rv_dly  = $urandom_range(1, 3);
      idx       = int'(v.addr[5:2]);
      v.rword   = mem[idx];
      model(v.f3, v.addr, v.wdata, v.rword, be, wd, rdv);
      v.exp_addr  = v.addr & 32'hFFFF_FFFC;
      v.exp_be    = be;
      v.exp_wdata = wd;
      v.exp_rdata = rdv;
      if (v.wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
